// File: rtl/switch_arbiter_if.sv
// Switch arbiter pin bundle: raw switch inputs, grant/status outputs and
// optional grant counters (present when SWITCH_ARBITER_CNT_EN is defined).
//   master : drives sw1/sw2, observes everything else (board side / bench)
//   slave  : the arbiter itself
interface switch_arbiter_if;
    logic       sw1;
    logic       sw2;
    logic       grant1;
    logic       grant2;
    logic       res_en;
    logic       busy;
    logic       pend1;
    logic       pend2;
`ifdef SWITCH_ARBITER_CNT_EN
    logic [7:0] grant_cnt1;
    logic [7:0] grant_cnt2;
`endif

    modport master (
        output sw1,
        output sw2,
        input  grant1,
        input  grant2,
        input  res_en,
        input  busy,
        input  pend1,
        input  pend2
`ifdef SWITCH_ARBITER_CNT_EN
        ,
        input  grant_cnt1,
        input  grant_cnt2
`endif
    );

    modport slave (
        input  sw1,
        input  sw2,
        output grant1,
        output grant2,
        output res_en,
        output busy,
        output pend1,
        output pend2
`ifdef SWITCH_ARBITER_CNT_EN
        ,
        output grant_cnt1,
        output grant_cnt2
`endif
    );
endinterface

// File: rtl/switch_arbiter.sv
// switch_arbiter: two raw front-panel switches are synchronised, debounced and
// rise-detected into pending requests; a round-robin FSM grants one shared
// resource for HOLD_CYCLES cycles, followed by one cooldown cycle.
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   arb    - switch_arbiter_if.slave: sw1/sw2 in; grant1/grant2/res_en/busy/
//            pend1/pend2 out; grant_cnt1/grant_cnt2 out with the macro below
// Optional feature macro: SWITCH_ARBITER_CNT_EN (saturating 8-bit grant counters)
module switch_arbiter #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    switch_arbiter_if.slave       arb
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_COOL  = 2'd2
    } state_e;

    state_e        state_q;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    db_q;
    logic [1:0]    db_dly_q;
    logic [CW-1:0] db_cnt_q [2];
    logic [1:0]    pend_q;
    logic [1:0]    grant_q;
    logic [HW-1:0] hold_q;
    logic          last2_q;     // 1: requester 2 was served last
    logic          busy_q;
    logic          res_en_q;

    logic [1:0]    sw_c;
    logic [1:0]    rise_c;
    logic [1:0]    win_c;
    logic          grant_start_c;

    // Request edge detect and round-robin winner selection
    always_comb begin
        sw_c          = {arb.sw2, arb.sw1};
        rise_c        = db_q & ~db_dly_q;
        win_c         = 2'b00;
        grant_start_c = (state_q == ST_IDLE) && (pend_q != 2'b00);
        if (grant_start_c) begin
            if (pend_q == 2'b11) begin
                win_c = last2_q ? 2'b01 : 2'b10;
            end else begin
                win_c = pend_q;
            end
        end
    end

    // Input conditioning, pending flags and the grant FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sync1_q  <= 2'b00;
            sync2_q  <= 2'b00;
            db_q     <= 2'b00;
            db_dly_q <= 2'b00;
            pend_q   <= 2'b00;
            grant_q  <= 2'b00;
            hold_q   <= '0;
            last2_q  <= 1'b1;
            busy_q   <= 1'b0;
            res_en_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sw_c;
            sync2_q  <= sync1_q;
            db_dly_q <= db_q;

            for (int i = 0; i < 2; i++) begin
                // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
                if (sync2_q[i] != db_q[i]) begin
                    if (db_cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        db_q[i]     <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + CW'(1);
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end

                // Clearing on the grant edge beats a coincident rise
                if (win_c[i]) begin
                    pend_q[i] <= 1'b0;
                end else if (rise_c[i]) begin
                    pend_q[i] <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (grant_start_c) begin
                        state_q  <= ST_GRANT;
                        grant_q  <= win_c;
                        last2_q  <= win_c[1];
                        hold_q   <= HW'(HOLD_CYCLES - 1);
                        busy_q   <= 1'b1;
                        res_en_q <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (hold_q == '0) begin
                        state_q  <= ST_COOL;
                        grant_q  <= 2'b00;
                        res_en_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q - HW'(1);
                    end
                end
                ST_COOL: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    grant_q  <= 2'b00;
                    busy_q   <= 1'b0;
                    res_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign arb.grant1 = grant_q[0];
    assign arb.grant2 = grant_q[1];
    assign arb.res_en = res_en_q;
    assign arb.busy   = busy_q;
    assign arb.pend1  = pend_q[0];
    assign arb.pend2  = pend_q[1];

`ifdef SWITCH_ARBITER_CNT_EN
    logic [7:0] gcnt_q [2];

    // Saturating per-requester grant counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                gcnt_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (win_c[i] && (gcnt_q[i] != 8'hFF)) begin
                    gcnt_q[i] <= gcnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign arb.grant_cnt1 = gcnt_q[0];
    assign arb.grant_cnt2 = gcnt_q[1];
`endif

endmodule
